cpu_data_mem: RTL
=================

# cpu_data_mem

Single-ported RV32 data memory responder. It sits on the data side of `cpu_top` and services load/store requests issued by the CPU's memory stage over a valid/ready request channel and a valid/ready response channel. It performs byte-lane selection and sign/zero extension for loads, and byte-enable generation for stores. Misaligned, out-of-range and illegal-size accesses are reported as errors.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words; legal range is 1 to 2^30.
- `LATENCY`, default 1: number of rising edges from request acceptance to response valid; legal range is 1 to 15.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `i_req_valid` in 1: request present.
- `o_req_ready` out 1: block can accept a request.
- `i_req_we` in 1: 1 = store, 0 = load.
- `i_req_addr` in 32: byte address.
- `i_req_funct3` in 3: RV32 load/store funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `i_req_wdata` in 32: store data, right-aligned.
- `o_rsp_valid` out 1: response present.
- `i_rsp_ready` in 1: CPU accepts the response.
- `o_rsp_rdata` out 32: load result, already extended.
- `o_rsp_err` out 1: access fault.

## Operation
- The FSM has three states: IDLE, BUSY and RESP.
- **IDLE**
  - `o_req_ready` = 1.
  - When `i_req_valid` is high at an edge, latch we, addr, funct3 and wdata.
  - Load the wait counter with `LATENCY`-1 and go to BUSY.
- **BUSY**
  - `o_req_ready` = 0.
  - Decrement the counter each edge.
  - At the edge where the counter is 0: perform the access, register the result and error, and go to RESP.
- **RESP**
  - `o_rsp_valid` = 1.
  - `o_rsp_rdata` and `o_rsp_err` stay constant until the handshake.
  - At the edge with `i_rsp_ready` = 1, go to IDLE.
  - There is no same-cycle re-accept: `o_req_ready` returns the cycle after the handshake.
- **Error conditions** (checked on the latched request):
  - H/HU with addr[0] ≠ 0.
  - W with addr[1:0] ≠ 0.
  - Word index addr[31:2] ≥ `DEPTH_WORDS`.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 not in {000, 001, 010}.
  - On error: no memory write, rdata = 0, err = 1.
- **Loads**
  - Select the byte lane using addr[1:0] (B/BU) or addr[1] (H/HU).
  - B and H are sign-extended; BU and HU are zero-extended; W returns the word unchanged.
- **Stores**
  - Byte enables:
    - B: one-hot on addr[1:0].
    - H: 0011 or 1100 per addr[1].
    - W: 1111.
  - Data is replicated across lanes: B → {4{wdata[7:0]}}, H → {2{wdata[15:0]}}.
  - Only enabled bytes change.
  - Response has rdata = 0, err = 0.
- Memory contents are not reset and are undefined until written.

## Timing
- **While `rst_n` = 0**, at each edge:
  - state = IDLE.
  - `o_req_ready` = 0, `o_rsp_valid` = 0, `o_rsp_rdata` = 0, `o_rsp_err` = 0.
  - `o_req_ready` rises in the first cycle after the edge that samples `rst_n` = 1.
- **Latency:** a request accepted at edge E0 has `o_rsp_valid` high from edge E0+`LATENCY` onward.
- **Minimum request spacing:** `LATENCY`+2 cycles, with `i_rsp_ready` held at 1.
- **Store commit:** a store commits at edge E0+`LATENCY`. A load issued afterwards returns the new data.
- **Request inputs:** sampled only at the accepting edge; changes while BUSY or RESP are ignored.
- **Response back-pressure:** `o_rsp_valid` must not drop, and rdata/err must not change, while `i_rsp_ready` = 0.
- **Reset mid-operation:**
  - Reset while in BUSY discards the request; the store is not committed.
  - Reset while in RESP discards the response.
  - State returns to IDLE with outputs at reset values.
- **Request while not ready:** `i_req_valid` asserted while `o_req_ready` = 0 is not accepted; the requester holds it.

## Test plan
- **Reset then word access:** reset, SW 0xDEADBEEF @0x10, then LW @0x10 → rdata = 0xDEADBEEF, err = 0. Each response is valid exactly `LATENCY` edges after acceptance.
- **Sub-word loads:** with 0x8081_7F01 @0x20:
  - LB @0x23 → 0xFFFFFF80.
  - LBU @0x23 → 0x00000080.
  - LH @0x22 → 0xFFFF8081.
  - LHU @0x20 → 0x00007F01.
  - LB @0x21 → 0x0000007F.
- **Sub-word stores:** word @0x30 = 0x11223344. SB 0xAA @0x31, then SH 0xBEEF @0x32 → LW @0x30 returns 0xBEEFAA44.
- **Errors:**
  - LW @0x06 → err = 1, rdata = 0.
  - SH @0x33 → err = 1, and a following LW @0x30 shows the word unchanged.
  - LW @(`DEPTH_WORDS`×4) → err = 1.
  - Load funct3 = 011 → err = 1.
- **Back-pressure:** hold `i_rsp_ready` = 0 for 5 cycles → `o_rsp_valid`, rdata and err stay stable. `o_req_ready` = 0 throughout, and returns 1 the cycle after the handshake.
- **Reset mid-op:** issue SW 0x12345678 @0x40 with `LATENCY` = 3 and assert `rst_n` = 0 while in BUSY → no response. A subsequent LW @0x40 returns the prior contents.

Source files
------------

// File: rtl/cpu_data_mem.sv
// cpu_data_mem: single-ported RV32 data memory responder.
// Accepts one load/store at a time over a valid/ready request channel and
// returns the result, after a fixed number of cycles, over a valid/ready
// response channel. Loads are lane-selected and extended; stores use byte
// enables. Misaligned, out-of-range and illegal-size accesses report err.
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high. The request side is ready only in IDLE. The response side
// holds o_rsp_valid, o_rsp_rdata and o_rsp_err stable until the edge where
// i_rsp_ready is high.
module cpu_data_mem #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [31:0] i_req_addr,
   input  logic [2:0]  i_req_funct3,
   input  logic [31:0] i_req_wdata,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err,
   output logic [1:0]  dbg_state
);

   localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] DEPTH_U    = 33'(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_START = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  cnt;

   // Request captured at the accepting edge; later input changes are ignored.
   logic        req_we;
   logic [31:0] req_addr;
   logic [2:0]  req_funct3;
   logic [31:0] req_wdata;

   // Storage is never reset; contents are undefined until written.
   logic [31:0] mem [DEPTH_WORDS];

   logic [29:0]   word_idx;
   logic [AW-1:0] mem_idx;
   logic          out_of_range;
   logic          funct3_bad;
   logic          misaligned;
   logic          acc_err;
   logic [31:0]   rd_word;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   load_data;
   logic [3:0]    byte_en;
   logic [31:0]   wdata_rep;
   logic          access_now;
   logic          commit;

   assign dbg_state = state;

   assign word_idx     = req_addr[31:2];
   assign mem_idx      = word_idx[AW-1:0];
   assign out_of_range = ({3'b000, word_idx} >= DEPTH_U);

   // Classify the latched request: legal size and alignment for its direction.
   always_comb begin
      funct3_bad = 1'b0;
      misaligned = 1'b0;
      if (req_we) begin
         funct3_bad = req_funct3[2] || (req_funct3[1:0] == 2'b11);
      end else begin
         funct3_bad = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
      end
      if (req_funct3[1:0] == 2'b01) begin
         misaligned = req_addr[0];
      end else if (req_funct3[1:0] == 2'b10) begin
         misaligned = (req_addr[1:0] != 2'b00);
      end
      acc_err = funct3_bad || misaligned || out_of_range;
   end

   // Load path: pick the addressed lane, then sign- or zero-extend it.
   always_comb begin
      rd_word = mem[mem_idx];
      case (req_addr[1:0])
         2'd0:    byte_sel = rd_word[7:0];
         2'd1:    byte_sel = rd_word[15:8];
         2'd2:    byte_sel = rd_word[23:16];
         default: byte_sel = rd_word[31:24];
      endcase
      half_sel = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
      case (req_funct3)
         3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_data = {24'd0, byte_sel};
         3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_data = {16'd0, half_sel};
         3'b010:  load_data = rd_word;
         default: load_data = 32'd0;
      endcase
   end

   // Store path: byte enables from size/offset, data replicated on all lanes.
   always_comb begin
      byte_en   = 4'b0000;
      wdata_rep = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            byte_en   = 4'b0001 << req_addr[1:0];
            wdata_rep = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            byte_en   = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            byte_en   = 4'b1111;
            wdata_rep = req_wdata;
         end
         default: begin
            byte_en   = 4'b0000;
            wdata_rep = req_wdata;
         end
      endcase
   end

   // The access happens on the last BUSY edge; reset suppresses the commit.
   assign access_now = (state == BUSY) && (cnt == 4'd0);
   assign commit     = rst_n && access_now && req_we && !acc_err;

   // Memory write: only enabled byte lanes change.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
               mem[mem_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
         end
      end
   end

   // Control FSM with registered handshake and response outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         o_req_ready <= 1'b0;
         o_rsp_valid <= 1'b0;
         o_rsp_rdata <= 32'd0;
         o_rsp_err   <= 1'b0;
         req_we      <= 1'b0;
         req_addr    <= 32'd0;
         req_funct3  <= 3'd0;
         req_wdata   <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (o_req_ready && i_req_valid) begin
                  req_we      <= i_req_we;
                  req_addr    <= i_req_addr;
                  req_funct3  <= i_req_funct3;
                  req_wdata   <= i_req_wdata;
                  cnt         <= WAIT_START;
                  o_req_ready <= 1'b0;
                  state       <= BUSY;
               end else begin
                  o_req_ready <= 1'b1;
               end
            end
            BUSY: begin
               if (cnt == 4'd0) begin
                  o_rsp_valid <= 1'b1;
                  o_rsp_rdata <= (acc_err || req_we) ? 32'd0 : load_data;
                  o_rsp_err   <= acc_err;
                  state       <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (i_rsp_ready) begin
                  o_rsp_valid <= 1'b0;
                  o_req_ready <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               o_req_ready <= 1'b0;
               o_rsp_valid <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule
